mac_tree_pipe: RTL and testbench

Parametrised, fully pipelined N-tap multiply-accumulate unit for the convolution datapath. It computes the dot product of N_TAPS signed operand pairs through a registered adder tree, then adds either its own accumulator or an external partial sum. Results are rounded and saturated to the output width. Each result carries a valid/ready handshake, a pass-through tag, and a saturation flag, so it can drive output memory and apply back-pressure.

---
 rtl/mac_tree_pipe.sv | 164 ++++++++++++++++
 tb/tb_mac_tree_pipe.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tree_pipe.sv
// mac_tree_pipe: N-tap signed dot product through a registered adder tree,
// accumulated against its own running sum or an external partial sum, then
// rounded and saturated. One valid/ready handshake freezes every stage.

// Per-tap multiplier with registered, sign-extended product.
module mac_tap #(
  parameter int A_WIDTH           = 16,
  parameter int B_WIDTH           = 16,
  parameter int ACCUMULATOR_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                arst_n_in,
  input  logic                                en,
  input  logic signed [A_WIDTH-1:0]           a,
  input  logic signed [B_WIDTH-1:0]           b,
  output logic        [ACCUMULATOR_WIDTH-1:0] prod_q
);
  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0] prod;
  assign prod = PW'(a) * PW'(b);

  // Stage P: product register, held while the pipe is frozen
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)  prod_q <= '0;
    else if (en)     prod_q <= ACCUMULATOR_WIDTH'(prod);
  end
endmodule

module mac_tree_pipe #(
  parameter int N_TAPS            = 3,
  parameter int A_WIDTH           = 16,
  parameter int B_WIDTH           = 16,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int OUTPUT_SCALE      = 0,
  parameter int TAG_WIDTH         = 32
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           accumulate_internal,
  input  logic [ACCUMULATOR_WIDTH-1:0]   partial_sum_in,
  input  logic [TAG_WIDTH-1:0]           tag_in,
  input  logic [N_TAPS*A_WIDTH-1:0]      a,
  input  logic [N_TAPS*B_WIDTH-1:0]      b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUT_WIDTH-1:0]        out,
  output logic [ACCUMULATOR_WIDTH-1:0]   acc_out,
  output logic [TAG_WIDTH-1:0]           tag_out,
  output logic                           out_saturated
);
  localparam int AW     = ACCUMULATOR_WIDTH;
  localparam int AW1    = AW + 1;
  localparam int D      = $clog2(N_TAPS);   // tree depth, 0 for a single tap
  localparam int STAGES = D + 1;            // P, T1..TD, then A at index STAGES

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 acc_int;
    logic [AW-1:0]        psum;
  } side_t;

  logic              advance;
  logic [STAGES:0]   vld_pipe;
  side_t             side_pipe [D+1];
  logic [AW-1:0]     tree_sum;
  logic [AW-1:0]     acc_reg;
  logic [TAG_WIDTH-1:0] tag_q;

  // A stalled, unconsumed result freezes the whole pipe
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // Valid bits and beat side-band shift alongside the data
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      vld_pipe <= '0;
      for (int k = 0; k <= D; k++) side_pipe[k] <= '0;
    end else if (advance) begin
      vld_pipe     <= {vld_pipe[STAGES-1:0], in_valid};
      side_pipe[0] <= '{tag: tag_in, acc_int: accumulate_internal, psum: partial_sum_in};
      for (int k = 1; k <= D; k++) side_pipe[k] <= side_pipe[k-1];
    end
  end

  // Level 0 holds products; each later level sums adjacent pairs, odd one passes
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int CNT = (N_TAPS + (1 << l) - 1) >> l;
    for (genvar i = 0; i < CNT; i++) begin : g_e
      logic [AW-1:0] q;
      if (l == 0) begin : g_leaf
        mac_tap #(
          .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .ACCUMULATOR_WIDTH(AW)
        ) u_tap (
          .clk(clk), .arst_n_in(arst_n_in), .en(advance),
          .a(a[i*A_WIDTH +: A_WIDTH]), .b(b[i*B_WIDTH +: B_WIDTH]),
          .prod_q(q)
        );
      end else begin : g_node
        localparam int PCNT = (N_TAPS + (1 << (l - 1)) - 1) >> (l - 1);
        if (2*i + 1 < PCNT) begin : g_add
          // Pair sum, wraps modulo 2^AW
          always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in)   q <= '0;
            else if (advance) q <= g_lvl[l-1].g_e[2*i].q + g_lvl[l-1].g_e[2*i+1].q;
          end
        end else begin : g_pass
          // Odd element rides through registered to keep alignment
          always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in)   q <= '0;
            else if (advance) q <= g_lvl[l-1].g_e[2*i].q;
          end
        end
      end
    end
  end

  assign tree_sum = g_lvl[D].g_e[0].q;

  // Stage A: only a real beat updates the accumulator and the presented tag
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc_reg <= '0;
      tag_q   <= '0;
    end else if (advance && vld_pipe[D]) begin
      acc_reg <= tree_sum + (side_pipe[D].acc_int ? acc_reg : side_pipe[D].psum);
      tag_q   <= side_pipe[D].tag;
    end
  end

  assign acc_out = acc_reg;
  assign tag_out = tag_q;

  // Output formatting, one extra bit so the rounding add cannot overflow
  logic signed [AW:0] acc_ext, scaled;
  assign acc_ext = {acc_reg[AW-1], acc_reg};

  if (OUTPUT_SCALE > 0) begin : g_rnd
    localparam logic signed [AW:0] RND = AW1'(1) <<< (OUTPUT_SCALE - 1);
    assign scaled = (acc_ext + RND) >>> OUTPUT_SCALE;
  end else begin : g_nornd
    assign scaled = acc_ext;
  end

  localparam logic signed [AW:0] OMAX = {{(AW-OUTPUT_WIDTH+2){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] OMIN = {{(AW-OUTPUT_WIDTH+2){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  // Clamp to the signed output range and flag any clipping
  always_comb begin
    out           = scaled[OUTPUT_WIDTH-1:0];
    out_saturated = 1'b0;
    if (scaled > OMAX) begin
      out           = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      out_saturated = 1'b1;
    end else if (scaled < OMIN) begin
      out           = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
      out_saturated = 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_tree_pipe.sv
// Bench for mac_tree_pipe: four instances (N=3, N=3 scaled by 2, N=1, N=5)
// share one accepted beat stream; a scoreboard queue holds per-instance
// expectations and each instance's output is compared as it is consumed.
module tb_mac_tree_pipe;
  localparam int NT  [4] = '{3, 3, 1, 5};
  localparam int SC  [4] = '{0, 2, 0, 0};
  localparam int LAT [4] = '{4, 4, 2, 5};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        drv_valid, out_ready, acc_int;
  logic [31:0] psum, tag;
  logic signed [15:0] ta [5];
  logic signed [15:0] tb [5];
  logic [47:0] a3, b3;
  logic [15:0] a1, b1;
  logic [79:0] a5, b5;
  assign a3 = {ta[2], ta[1], ta[0]};
  assign b3 = {tb[2], tb[1], tb[0]};
  assign a1 = ta[0];
  assign b1 = tb[0];
  assign a5 = {ta[4], ta[3], ta[2], ta[1], ta[0]};
  assign b5 = {tb[4], tb[3], tb[2], tb[1], tb[0]};

  logic [3:0]  ir, ov, sat;
  logic [15:0] o  [4];
  logic [31:0] ao [4];
  logic [31:0] to [4];
  logic        rdy_all, vin;
  // all instances accept exactly the same beats
  assign rdy_all = &ir;
  assign vin     = drv_valid & rdy_all;

  mac_tree_pipe #(.N_TAPS(3)) u3 (
    .clk(clk), .arst_n_in(rst_n), .in_valid(vin), .in_ready(ir[0]),
    .accumulate_internal(acc_int), .partial_sum_in(psum), .tag_in(tag),
    .a(a3), .b(b3), .out_valid(ov[0]), .out_ready(out_ready), .out(o[0]),
    .acc_out(ao[0]), .tag_out(to[0]), .out_saturated(sat[0]));
  mac_tree_pipe #(.N_TAPS(3), .OUTPUT_SCALE(2)) u3s (
    .clk(clk), .arst_n_in(rst_n), .in_valid(vin), .in_ready(ir[1]),
    .accumulate_internal(acc_int), .partial_sum_in(psum), .tag_in(tag),
    .a(a3), .b(b3), .out_valid(ov[1]), .out_ready(out_ready), .out(o[1]),
    .acc_out(ao[1]), .tag_out(to[1]), .out_saturated(sat[1]));
  mac_tree_pipe #(.N_TAPS(1)) u1 (
    .clk(clk), .arst_n_in(rst_n), .in_valid(vin), .in_ready(ir[2]),
    .accumulate_internal(acc_int), .partial_sum_in(psum), .tag_in(tag),
    .a(a1), .b(b1), .out_valid(ov[2]), .out_ready(out_ready), .out(o[2]),
    .acc_out(ao[2]), .tag_out(to[2]), .out_saturated(sat[2]));
  mac_tree_pipe #(.N_TAPS(5)) u5 (
    .clk(clk), .arst_n_in(rst_n), .in_valid(vin), .in_ready(ir[3]),
    .accumulate_internal(acc_int), .partial_sum_in(psum), .tag_in(tag),
    .a(a5), .b(b5), .out_valid(ov[3]), .out_ready(out_ready), .out(o[3]),
    .acc_out(ao[3]), .tag_out(to[3]), .out_saturated(sat[3]));

  typedef struct packed {
    logic [3:0][15:0] o;
    logic [3:0][31:0] acc;
    logic [3:0]       sat;
    logic [31:0]      tag;
    logic [31:0]      cyc;
    logic [3:0][31:0] frz;
  } beat_t;

  beat_t sb[$];
  int rp  [4];
  int frz [4];
  logic signed [31:0] m [4];
  int cyc, total, bad;

  function automatic logic signed [31:0] dot(input int n);
    logic signed [31:0] s;
    s = 0;
    for (int i = 0; i < n; i++) s += 32'(ta[i]) * 32'(tb[i]);
    return s;
  endfunction

  function automatic void fmt(input logic signed [31:0] acc, input int sc,
                              output logic [15:0] r, output logic s);
    logic signed [32:0] e;
    e = {acc[31], acc};
    if (sc > 0) e = (e + (33'sd1 <<< (sc - 1))) >>> sc;
    s = 1'b1;
    if (e > 33'sd32767)       r = 16'h7fff;
    else if (e < -33'sd32768) r = 16'h8000;
    else begin r = e[15:0]; s = 1'b0; end
  endfunction

  // One clock: drive at negedge, score consumed outputs, push accepted beat
  task automatic step(input bit v, input bit ordy, output bit ok, output logic [3:0] irs);
    beat_t bt;
    logic [15:0] r;
    logic s;
    int lat;
    @(negedge clk);
    drv_valid = v;
    out_ready = ordy;
    #1;
    irs = ir;
    for (int d = 0; d < 4; d++) begin
      if (ov[d] && out_ready) begin
        total++;
        if (rp[d] >= sb.size()) begin
          bad++;
          $display("FAIL spurious_out dut%0d got tag=%h acc=%h exp no output", d, to[d], ao[d]);
        end else begin
          bt = sb[rp[d]];
          rp[d]++;
          if ({o[d], ao[d], to[d], sat[d]} !== {bt.o[d], bt.acc[d], bt.tag, bt.sat[d]}) begin
            bad++;
            $display("FAIL result dut%0d got out=%h acc=%h tag=%h sat=%b exp out=%h acc=%h tag=%h sat=%b",
                     d, o[d], ao[d], to[d], sat[d], bt.o[d], bt.acc[d], bt.tag, bt.sat[d]);
          end
          total++;
          lat = cyc - int'(bt.cyc) - (frz[d] - int'(bt.frz[d]));
          if (lat != LAT[d]) begin
            bad++;
            $display("FAIL latency dut%0d tag=%h got=%0d exp=%0d", d, bt.tag, lat, LAT[d]);
          end
        end
      end else if (ov[d]) frz[d]++;
    end
    while (sb.size() > 0 && rp[0] > 0 && rp[1] > 0 && rp[2] > 0 && rp[3] > 0) begin
      void'(sb.pop_front());
      for (int d = 0; d < 4; d++) rp[d]--;
    end
    ok = v && rdy_all;
    if (ok) begin
      bt.tag = tag;
      bt.cyc = 32'(cyc);
      for (int d = 0; d < 4; d++) begin
        m[d] = (acc_int ? m[d] : $signed(psum)) + dot(NT[d]);
        fmt(m[d], SC[d], r, s);
        bt.o[d]   = r;
        bt.acc[d] = m[d];
        bt.sat[d] = s;
        bt.frz[d] = 32'(frz[d]);
      end
      sb.push_back(bt);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input bit ai, input logic [31:0] ps, input logic [31:0] tg);
    bit ok;
    logic [3:0] irs;
    int n;
    n = 0;
    acc_int = ai; psum = ps; tag = tg;
    do begin step(1'b1, 1'b1, ok, irs); n++; end while (!ok && n < 50);
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout tag=%h got no accept exp accept within 50", tg);
    end
  endtask

  task automatic drain();
    bit ok;
    logic [3:0] irs;
    int n;
    n = 0;
    while ((rp[0] < sb.size() || rp[1] < sb.size() || rp[2] < sb.size() || rp[3] < sb.size()) && n < 60) begin
      step(1'b0, 1'b1, ok, irs);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d exp 0", sb.size() - rp[0]);
    end
  endtask

  task automatic clear_taps();
    for (int i = 0; i < 5; i++) begin ta[i] = 16'sd0; tb[i] = 16'sd0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({ov[d], o[d], ao[d], to[d], sat[d], ir[d]} !== {1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL reset_state dut%0d got v=%b out=%h acc=%h tag=%h sat=%b rdy=%b exp 0/0/0/0/0/1",
                 d, ov[d], o[d], ao[d], to[d], sat[d], ir[d]);
      end
    end
  endtask

  task automatic test_single();
    ta = '{16'sd1, 16'sd2, 16'sd3, 16'sd7, -16'sd2};
    tb = '{16'sd4, 16'sd5, 16'sd6, 16'sd3, 16'sd9};
    send(1'b0, 32'd10, 32'h5);
    drain();
    total++;
    if ({o[0], ao[0], to[0]} !== {16'd42, 32'd42, 32'h5}) begin
      bad++;
      $display("FAIL single_beat got out=%h acc=%h tag=%h exp out=002a acc=0000002a tag=5", o[0], ao[0], to[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] irs;
    clear_taps();
    ta[0] = 16'sd1; ta[1] = 16'sd2; ta[2] = 16'sd3;
    tb[0] = 16'sd2; tb[1] = 16'sd3; tb[2] = 16'sd8;
    send(1'b0, 32'd0, 32'h11);
    send(1'b1, 32'd0, 32'h12);
    send(1'b1, 32'd0, 32'h13);
    step(1'b0, 1'b1, ok, irs);
    step(1'b0, 1'b1, ok, irs);
    send(1'b1, 32'd0, 32'h14);
    drain();
    total++;
    if ({o[0], ao[0]} !== {16'd128, 32'd128}) begin
      bad++;
      $display("FAIL accumulate_chain got out=%h acc=%h exp out=0080 acc=00000080", o[0], ao[0]);
    end
  endtask

  task automatic test_saturation();
    clear_taps();
    ta[0] = 16'sd300; tb[0] = 16'sd200;
    send(1'b0, 32'd0, 32'h21);
    drain();
    total++;
    if ({o[0], sat[0], ao[0]} !== {16'h7fff, 1'b1, 32'd60000}) begin
      bad++;
      $display("FAIL sat_pos got out=%h sat=%b acc=%h exp out=7fff sat=1 acc=0000ea60", o[0], sat[0], ao[0]);
    end
    ta[0] = -16'sd300;
    send(1'b0, 32'd0, 32'h22);
    drain();
    total++;
    if ({o[0], sat[0]} !== {16'h8000, 1'b1}) begin
      bad++;
      $display("FAIL sat_neg got out=%h sat=%b exp out=8000 sat=1", o[0], sat[0]);
    end
    ta[0] = 16'sd1; tb[0] = 16'sd1;
    send(1'b0, 32'h7fffffff, 32'h23);
    drain();
    total++;
    if (ao[0] !== 32'h80000000) begin
      bad++;
      $display("FAIL acc_wrap got acc=%h exp acc=80000000", ao[0]);
    end
  endtask

  task automatic test_rounding();
    int dv [4] = '{6, 5, -6, -7};
    int ex [4] = '{2, 1, -1, -2};
    logic [15:0] e;
    clear_taps();
    tb[0] = 16'sd1;
    for (int k = 0; k < 4; k++) begin
      ta[0] = 16'(dv[k]);
      send(1'b0, 32'd0, 32'(32 + k));
      drain();
      e = 16'(ex[k]);
      total++;
      if (o[1] !== e) begin
        bad++;
        $display("FAIL round dot=%0d got out=%h exp out=%h", dv[k], o[1], e);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] irs;
    int nb, loaded;
    logic [3:0]  hv, hs;
    logic [15:0] ho [4];
    logic [31:0] ha [4];
    logic [31:0] ht [4];
    nb = 0; loaded = -1;
    for (int k = 0; k < 20; k++) begin
      if (nb < 8 && loaded != nb) begin
        for (int i = 0; i < 5; i++) begin
          ta[i] = 16'(int'($urandom_range(0, 400)) - 200);
          tb[i] = 16'(int'($urandom_range(0, 400)) - 200);
        end
        acc_int = 1'($urandom_range(0, 1));
        psum    = 32'($urandom_range(0, 5000));
        tag     = 32'(nb);
        loaded  = nb;
      end
      step(nb < 8, !(k >= 5 && k < 10), ok, irs);
      if (ok) nb++;
      if (k == 5 || k == 10) begin
        total++;
        if (irs !== ((k == 5) ? 4'b0000 : 4'b1111)) begin
          bad++;
          $display("FAIL in_ready_stall cycle=%0d got=%b exp=%b", k, irs, (k == 5) ? 4'b0000 : 4'b1111);
        end
      end
      if (k == 4) begin
        hv = ov; hs = sat;
        for (int d = 0; d < 4; d++) begin ho[d] = o[d]; ha[d] = ao[d]; ht[d] = to[d]; end
      end else if (k >= 5 && k <= 9) begin
        for (int d = 0; d < 4; d++) begin
          total++;
          if ({ov[d], o[d], ao[d], to[d], sat[d]} !== {1'b1, ho[d], ha[d], ht[d], hs[d]} || !hv[d]) begin
            bad++;
            $display("FAIL hold_stable dut%0d cycle=%0d got v=%b out=%h acc=%h tag=%h exp v=1 out=%h acc=%h tag=%h",
                     d, k, ov[d], o[d], ao[d], to[d], ho[d], ha[d], ht[d]);
          end
        end
      end
    end
    drain();
    total++;
    if (nb != 8) begin
      bad++;
      $display("FAIL bp_beats got=%0d exp=8", nb);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [3:0] irs;
    clear_taps();
    ta[0] = 16'sd1; ta[1] = 16'sd2; ta[2] = 16'sd3;
    tb[0] = 16'sd2; tb[1] = 16'sd3; tb[2] = 16'sd8;
    send(1'b1, 32'd0, 32'h41);
    send(1'b1, 32'd0, 32'h42);
    send(1'b1, 32'd0, 32'h43);
    @(negedge clk);
    drv_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({ov[d], o[d], ao[d], to[d], sat[d]} !== 82'h0) begin
        bad++;
        $display("FAIL reset_mid dut%0d got v=%b out=%h acc=%h tag=%h sat=%b exp all 0",
                 d, ov[d], o[d], ao[d], to[d], sat[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int d = 0; d < 4; d++) begin rp[d] = 0; m[d] = 0; end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, ok, irs);
      total++;
      if (ov !== 4'b0000) begin
        bad++;
        $display("FAIL post_reset_valid cycle=%0d got=%b exp=0000", k, ov);
      end
    end
    send(1'b1, 32'd0, 32'h77);
    drain();
    total++;
    if ({o[0], ao[0], to[0]} !== {16'd32, 32'd32, 32'h77}) begin
      bad++;
      $display("FAIL first_after_reset got out=%h acc=%h tag=%h exp out=0020 acc=00000020 tag=77", o[0], ao[0], to[0]);
    end
  endtask

  initial begin
    drv_valid = 1'b0; out_ready = 1'b1; acc_int = 1'b0; psum = '0; tag = '0;
    clear_taps();
    rst_n = 1'b0;
    total = 0; bad = 0; cyc = 0;
    for (int d = 0; d < 4; d++) begin rp[d] = 0; frz[d] = 0; m[d] = 0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
